pipe_controller_r1: RTL and testbench

// - Next-generation main controller for the 5-stage MIPS pipeline: decodes opcode/funcode in ID, carries
//   the control word through ID/EX, EX/MEM, MEM/WB registers, and owns load-use/branch hazard stalls and
//   IF/ID flush. Sits beside the ID-stage register file; datapath muxes read the per-stage control outputs.

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/ctrl_decode.sv | 94 +++++++++
 rtl/pipe_controller_r1.sv | 104 ++++++++++
 tb/tb_pipe_controller_r1.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared MIPS opcode/funct codes, control field encodings and pipeline control word types
package ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1a, FN_DIVU = 6'h1b;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2a;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_RTYPE = 3'd7;
  localparam logic [1:0] RWS_ALU = 2'd0, RWS_LUI = 2'd1, RWS_PC4 = 2'd2;
  localparam logic [1:0] LS_BYTE = 2'd0, LS_HALF = 2'd1, LS_WORD = 2'd2;
  typedef struct packed {
    logic       aluSrc;
    logic       isSigned;
    logic [2:0] aluOp;
    logic       memRead;
    logic [3:0] memWrite;
    logic [1:0] loadSize;
    logic       loadSigned;
    logic       regWrite;
    logic       memtoReg;
    logic [1:0] regWriteSrc;
  } ctrl_word_t;
  typedef struct packed {
    logic jump;
    logic jumpReg;
    logic branchBeq;
    logic branchBne;
    logic usesRt;
    logic mulDiv;
    logic hiLoUse;
  } id_ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funcode decode into the pipelined control word (CTRL_MULDIV_EN adds HI/LO ops)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funcode,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output ctrl_word_t            word,
  output id_ctrl_t              idCtrl,
  output logic [REG_ADDR_W-1:0] wrAddr
);
  logic [REG_ADDR_W-1:0] dest;
  always_comb begin
    word = '0;
    idCtrl = '0;
    dest = '0;
    word.regWriteSrc = RWS_ALU;
    case (opcode)
      OP_RTYPE: begin
        idCtrl.usesRt = 1'b1;
        case (funcode)
          FN_JR: idCtrl.jumpReg = 1'b1;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
`ifdef CTRL_MULDIV_EN
            word.aluOp = ALU_RTYPE;
            word.isSigned = funcode == FN_MULT || funcode == FN_DIV;
            idCtrl.mulDiv = 1'b1;
            idCtrl.hiLoUse = 1'b1;
`endif
          end
          FN_MFHI, FN_MFLO: begin
`ifdef CTRL_MULDIV_EN
            word.aluOp = ALU_RTYPE;
            word.regWrite = 1'b1;
            dest = rd;
            idCtrl.hiLoUse = 1'b1;
`endif
          end
          default: begin
            word.aluOp = ALU_RTYPE;
            word.regWrite = 1'b1;
            word.isSigned = funcode == FN_ADD || funcode == FN_SUB || funcode == FN_SLT;
            dest = rd;
          end
        endcase
      end
      OP_J: idCtrl.jump = 1'b1;
      OP_JAL: begin
        idCtrl.jump = 1'b1;
        word.regWrite = 1'b1;
        word.regWriteSrc = RWS_PC4;
        dest = REG_ADDR_W'(31);
      end
      OP_BEQ, OP_BNE: begin
        word.aluOp = ALU_SUB;
        idCtrl.usesRt = 1'b1;
        idCtrl.branchBeq = opcode == OP_BEQ;
        idCtrl.branchBne = opcode == OP_BNE;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        word.aluSrc = 1'b1;
        word.regWrite = 1'b1;
        word.isSigned = opcode == OP_ADDI || opcode == OP_SLTI;
        word.aluOp = (opcode == OP_SLTI || opcode == OP_SLTIU) ? ALU_SLT :
                     opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR :
                     opcode == OP_XORI ? ALU_XOR : ALU_ADD;
        word.regWriteSrc = opcode == OP_LUI ? RWS_LUI : RWS_ALU;
        dest = rt;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        word.aluSrc = 1'b1;
        word.aluOp = ALU_ADD;
        word.memRead = 1'b1;
        word.memtoReg = 1'b1;
        word.regWrite = 1'b1;
        word.loadSize = opcode == OP_LW ? LS_WORD : (opcode == OP_LH || opcode == OP_LHU) ? LS_HALF : LS_BYTE;
        word.loadSigned = opcode == OP_LB || opcode == OP_LH;
        dest = rt;
      end
      OP_SB, OP_SH, OP_SW: begin
        word.aluSrc = 1'b1;
        word.aluOp = ALU_ADD;
        word.memWrite = opcode == OP_SW ? 4'b1111 : opcode == OP_SH ? 4'b0011 : 4'b0001;
        idCtrl.usesRt = 1'b1;
      end
      default: ;
    endcase
    word.regWrite = word.regWrite && dest != '0;
    wrAddr = word.regWrite ? dest : '0;
  end
endmodule

// File: rtl/pipe_controller_r1.sv
// pipe_controller_r1: MIPS 5-stage control pipeline with load-use/branch stalls and IF/ID flush; CTRL_MULDIV_EN adds HI/LO busy stall
module pipe_controller_r1
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int BYTE_LANES     = 4,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funcode,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  branch_eq_id,
  output logic                  id_Jump,
  output logic                  id_JumpRegID,
  output logic                  id_BranchBEQ,
  output logic                  id_BranchBNE,
  output logic                  stall_id,
  output logic                  flush_if_id,
  output logic                  ex_ALUSrc,
  output logic                  ex_isSigned,
  output logic [2:0]            ex_ALUOp,
  output logic [REG_ADDR_W-1:0] ex_wr_addr,
  output logic                  mem_MemRead,
  output logic [BYTE_LANES-1:0] mem_MemWrite,
  output logic [1:0]            mem_LoadSize,
  output logic                  mem_LoadSigned,
  output logic                  wb_RegWrite,
  output logic                  wb_MemtoReg,
  output logic [1:0]            wb_RegWriteSrc,
  output logic [REG_ADDR_W-1:0] wb_wr_addr
);
  ctrl_word_t idWord, exWord, memWord, wbWord;
  id_ctrl_t idCtrl;
  logic [REG_ADDR_W-1:0] idWr, exWr, memWr, wbWr;
  logic loadUse, branchHaz, busyHaz, hazard, taken, unusedBits;
  ctrl_decode #(.REG_ADDR_W(REG_ADDR_W)) uDecode (
    .opcode (opcode),
    .funcode(funcode),
    .rt     (rt_id),
    .rd     (rd_id),
    .word   (idWord),
    .idCtrl (idCtrl),
    .wrAddr (idWr)
  );
  assign loadUse = exWord.memRead && exWr != '0 && (exWr == rs_id || (idCtrl.usesRt && exWr == rt_id));
  assign branchHaz = (idCtrl.branchBeq || idCtrl.branchBne || idCtrl.jumpReg) &&
                     ((exWord.regWrite && (exWr == rs_id || exWr == rt_id)) ||
                      (memWord.memRead && memWord.regWrite && (memWr == rs_id || memWr == rt_id)));
`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_LATENCY + 1);
  logic [CNT_W-1:0] busyCnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busyCnt <= '0;
    else busyCnt <= (idCtrl.mulDiv && !hazard) ? CNT_W'(MULDIV_LATENCY) : busyCnt != '0 ? busyCnt - 1'b1 : busyCnt;
  end
  assign busyHaz = idCtrl.hiLoUse && busyCnt != '0;
`else
  assign busyHaz = 1'b0;
`endif
  assign hazard = loadUse || branchHaz || busyHaz;
  assign taken = idCtrl.jump || idCtrl.jumpReg || (idCtrl.branchBeq && branch_eq_id) || (idCtrl.branchBne && !branch_eq_id);
  assign stall_id = !rst && hazard;
  assign flush_if_id = !rst && !hazard && taken;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exWord <= '0;
      memWord <= '0;
      wbWord <= '0;
      exWr <= '0;
      memWr <= '0;
      wbWr <= '0;
    end else begin
      exWord <= hazard ? '0 : idWord;
      exWr <= hazard ? '0 : idWr;
      memWord <= exWord;
      memWr <= exWr;
      wbWord <= memWord;
      wbWr <= memWr;
    end
  end
  assign id_Jump = idCtrl.jump;
  assign id_JumpRegID = idCtrl.jumpReg;
  assign id_BranchBEQ = idCtrl.branchBeq;
  assign id_BranchBNE = idCtrl.branchBne;
  assign ex_ALUSrc = exWord.aluSrc;
  assign ex_isSigned = exWord.isSigned;
  assign ex_ALUOp = exWord.aluOp;
  assign ex_wr_addr = exWr;
  assign mem_MemRead = memWord.memRead;
  assign mem_MemWrite = BYTE_LANES'(memWord.memWrite);
  assign mem_LoadSize = memWord.loadSize;
  assign mem_LoadSigned = memWord.loadSigned;
  assign wb_RegWrite = wbWord.regWrite;
  assign wb_MemtoReg = wbWord.memtoReg;
  assign wb_RegWriteSrc = wbWord.regWriteSrc;
  assign wb_wr_addr = wbWr;
  assign unusedBits = ^{memWord.aluSrc, memWord.isSigned, memWord.aluOp, wbWord.aluSrc, wbWord.isSigned,
                        wbWord.aluOp, wbWord.memRead, wbWord.memWrite, wbWord.loadSize, wbWord.loadSigned,
                        idCtrl.mulDiv, idCtrl.hiLoUse};
endmodule

// File: tb/tb_pipe_controller_r1.sv
// tb_pipe_controller_r1: directed and random instruction streams checked against an instruction-level pipeline model
module tb_pipe_controller_r1;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, funcode = '0;
  logic [4:0] rs_id = '0, rt_id = '0, rd_id = '0;
  logic branch_eq_id = 1'b0;
  logic id_Jump, id_JumpRegID, id_BranchBEQ, id_BranchBNE, stall_id, flush_if_id;
  logic ex_ALUSrc, ex_isSigned, mem_MemRead, mem_LoadSigned, wb_RegWrite, wb_MemtoReg;
  logic [2:0] ex_ALUOp;
  logic [4:0] ex_wr_addr, wb_wr_addr;
  logic [3:0] mem_MemWrite;
  logic [1:0] mem_LoadSize, wb_RegWriteSrc;
  always #5 clk = ~clk;
  pipe_controller_r1 dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funcode(funcode), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .branch_eq_id(branch_eq_id), .id_Jump(id_Jump), .id_JumpRegID(id_JumpRegID), .id_BranchBEQ(id_BranchBEQ),
    .id_BranchBNE(id_BranchBNE), .stall_id(stall_id), .flush_if_id(flush_if_id), .ex_ALUSrc(ex_ALUSrc),
    .ex_isSigned(ex_isSigned), .ex_ALUOp(ex_ALUOp), .ex_wr_addr(ex_wr_addr), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_LoadSize(mem_LoadSize), .mem_LoadSigned(mem_LoadSigned),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_RegWriteSrc(wb_RegWriteSrc), .wb_wr_addr(wb_wr_addr)
  );
`ifdef CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MD_LAT = 4;
  typedef struct {
    int aluSrc, isSigned, aluOp, memRead, memWrite, loadSize, loadSigned;
    int regWrite, memtoReg, rws, wr, jump, jr, beq, bne, usesRt, md, hl;
  } ins_t;
  ins_t pipe [3];
  int busy;
  int nCompared = 0, nMismatched = 0;
  int lastFlush;
  logic [5:0] opTbl [30] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h04, 6'h05, 6'h05,
                             6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                             6'h20, 6'h21, 6'h23, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h3f};
  logic [5:0] fnTbl [13] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h08, 6'h18, 6'h1a, 6'h10, 6'h12, 6'h00};
  task automatic check(input string tag, input int got, input int exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic ins_t decode(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt, input logic [4:0] rd);
    ins_t d = '{default: 0};
    int dest = 0;
    if (op == 6'h00) begin
      d.usesRt = 1;
      if (fn == 6'h08) d.jr = 1;
      else if (fn inside {6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b}) begin
        if (MD) begin
          d.hl = 1;
          d.aluOp = 7;
          d.md = int'(fn >= 6'h18);
          d.isSigned = int'(fn inside {6'h18, 6'h1a});
          d.regWrite = int'(fn < 6'h18);
          dest = (fn < 6'h18) ? int'(rd) : 0;
        end
      end else begin
        d.aluOp = 7;
        d.regWrite = 1;
        d.isSigned = int'(fn inside {6'h20, 6'h22, 6'h2a});
        dest = int'(rd);
      end
    end else if (op == 6'h02 || op == 6'h03) begin
      d.jump = 1;
      if (op == 6'h03) begin
        d.regWrite = 1;
        d.rws = 2;
        dest = 31;
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      d.aluOp = 1;
      d.usesRt = 1;
      d.beq = int'(op == 6'h04);
      d.bne = int'(op == 6'h05);
    end else if (op inside {[6'h08:6'h0f]}) begin
      d.aluSrc = 1;
      d.regWrite = 1;
      d.isSigned = int'(op == 6'h08 || op == 6'h0a);
      d.aluOp = (op == 6'h0a || op == 6'h0b) ? 5 : op == 6'h0c ? 2 : op == 6'h0d ? 3 : op == 6'h0e ? 4 : 0;
      d.rws = (op == 6'h0f) ? 1 : 0;
      dest = int'(rt);
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      d.aluSrc = 1;
      d.memRead = 1;
      d.memtoReg = 1;
      d.regWrite = 1;
      d.loadSize = (op == 6'h23) ? 2 : (op inside {6'h21, 6'h25}) ? 1 : 0;
      d.loadSigned = int'(op inside {6'h20, 6'h21});
      dest = int'(rt);
    end else if (op inside {6'h28, 6'h29, 6'h2b}) begin
      d.aluSrc = 1;
      d.usesRt = 1;
      d.memWrite = (op == 6'h2b) ? 15 : (op == 6'h29) ? 3 : 1;
    end
    if (dest == 0) d.regWrite = 0;
    d.wr = (d.regWrite != 0) ? dest : 0;
    return d;
  endfunction
  task automatic resetModel();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    busy = 0;
  endtask
  task automatic compareAll(output bit st, output ins_t id);
    ins_t ex, mem, wb;
    bit lu, br, bz, fl;
    id = decode(opcode, funcode, rt_id, rd_id);
    ex = pipe[0];
    mem = pipe[1];
    wb = pipe[2];
    lu = ex.memRead != 0 && ex.wr != 0 && (ex.wr == int'(rs_id) || (id.usesRt != 0 && ex.wr == int'(rt_id)));
    br = (id.beq != 0 || id.bne != 0 || id.jr != 0) &&
         ((ex.regWrite != 0 && (ex.wr == int'(rs_id) || ex.wr == int'(rt_id))) ||
          (mem.memRead != 0 && mem.regWrite != 0 && (mem.wr == int'(rs_id) || mem.wr == int'(rt_id))));
    bz = id.hl != 0 && busy > 0;
    st = lu || br || bz;
    fl = !st && (id.jump != 0 || id.jr != 0 || (id.beq != 0 && branch_eq_id) || (id.bne != 0 && !branch_eq_id));
    check("id_Jump", id_Jump, id.jump);
    check("id_JumpRegID", id_JumpRegID, id.jr);
    check("id_BranchBEQ", id_BranchBEQ, id.beq);
    check("id_BranchBNE", id_BranchBNE, id.bne);
    check("stall_id", stall_id, int'(st));
    check("flush_if_id", flush_if_id, int'(fl));
    check("ex_ALUSrc", ex_ALUSrc, ex.aluSrc);
    check("ex_isSigned", ex_isSigned, ex.isSigned);
    check("ex_ALUOp", ex_ALUOp, ex.aluOp);
    check("ex_wr_addr", ex_wr_addr, ex.wr);
    check("mem_MemRead", mem_MemRead, mem.memRead);
    check("mem_MemWrite", mem_MemWrite, mem.memWrite);
    check("mem_LoadSize", mem_LoadSize, mem.loadSize);
    check("mem_LoadSigned", mem_LoadSigned, mem.loadSigned);
    check("wb_RegWrite", wb_RegWrite, wb.regWrite);
    check("wb_MemtoReg", wb_MemtoReg, wb.memtoReg);
    check("wb_RegWriteSrc", wb_RegWriteSrc, wb.rws);
    check("wb_wr_addr", wb_wr_addr, wb.wr);
  endtask
  task automatic advance(input ins_t id, input bit st);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (st) pipe[0] = '{default: 0};
    else pipe[0] = id;
    busy = (id.md != 0 && !st) ? MD_LAT : (busy > 0 ? busy - 1 : 0);
  endtask
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic eq, input int expStalls, input string tag);
    bit st;
    ins_t id;
    int nd = 0, guard = 0;
    opcode = op;
    funcode = fn;
    rs_id = rs;
    rt_id = rt;
    rd_id = rd;
    branch_eq_id = eq;
    do begin
      #1;
      compareAll(st, id);
      nd += int'(stall_id);
      lastFlush = int'(flush_if_id);
      @(posedge clk);
      advance(id, st);
      @(negedge clk);
      guard++;
    end while (st && guard < 20);
    if (guard >= 20) check({tag, "_stall_bound"}, guard, 0);
    if (expStalls >= 0) check(tag, nd, expStalls);
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, -1, "nop");
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    resetModel();
    opcode = 6'h04;
    rs_id = 5'd1;
    rt_id = 5'd2;
    branch_eq_id = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall_id, 0);
    check("rst_flush", flush_if_id, 0);
    check("rst_idBeq", id_BranchBEQ, 1);
    check("rst_exAluOp", ex_ALUOp, 0);
    check("rst_memWrite", mem_MemWrite, 0);
    check("rst_wbRegWrite", wb_RegWrite, 0);
    check("rst_wbWr", wb_wr_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    nops(3);
    issue(6'h23, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0, -1, "lw");
    issue(6'h00, 6'h20, 5'd8, 5'd11, 5'd10, 1'b0, 1, "loaduse_stalls");
    check("loaduse_exWr", ex_wr_addr, 10);
    nops(3);
    issue(6'h23, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0, -1, "lw");
    issue(6'h00, 6'h20, 5'd0, 5'd12, 5'd10, 1'b0, 0, "nodep_stalls");
    nops(1);
    check("nodep_wbRegWrite", wb_RegWrite, 1);
    check("nodep_wbWr", wb_wr_addr, 8);
    nops(3);
    issue(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1, 0, "beq_stalls");
    check("beq_flush", lastFlush, 1);
    issue(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1, 0, "bne_stalls");
    check("bne_flush", lastFlush, 0);
    nops(3);
    issue(6'h08, 6'h00, 5'd0, 5'd3, 5'd0, 1'b0, -1, "addi");
    issue(6'h04, 6'h00, 5'd3, 5'd0, 5'd0, 1'b1, 1, "addi_beq_stalls");
    check("addi_beq_flush", lastFlush, 1);
    nops(3);
    issue(6'h23, 6'h00, 5'd9, 5'd3, 5'd0, 1'b0, -1, "lw");
    issue(6'h04, 6'h00, 5'd3, 5'd0, 5'd0, 1'b1, 2, "lw_beq_stalls");
    check("lw_beq_flush", lastFlush, 1);
    nops(3);
    issue(6'h29, 6'h00, 5'd9, 5'd4, 5'd0, 1'b0, -1, "sh");
    nops(1);
    check("sh_memWrite", mem_MemWrite, 3);
    issue(6'h21, 6'h00, 5'd9, 5'd5, 5'd0, 1'b0, -1, "lh");
    nops(1);
    check("lh_loadSize", mem_LoadSize, 1);
    check("lh_loadSigned", mem_LoadSigned, 1);
    issue(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0, -1, "addi0");
    nops(2);
    check("addi0_wbRegWrite", wb_RegWrite, 0);
    nops(3);
    issue(6'h23, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0, -1, "lw");
    opcode = 6'h00;
    funcode = 6'h20;
    rs_id = 5'd8;
    rt_id = 5'd11;
    rd_id = 5'd10;
    #1;
    check("midrst_pre_stall", stall_id, 1);
    check("midrst_pre_exWr", ex_wr_addr, 8);
    rst = 1'b1;
    #1;
    check("midrst_stall", stall_id, 0);
    check("midrst_exAluSrc", ex_ALUSrc, 0);
    check("midrst_exWr", ex_wr_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    issue(6'h00, 6'h20, 5'd8, 5'd11, 5'd10, 1'b0, 0, "midrst_post_stalls");
`ifdef CTRL_MULDIV_EN
    nops(3);
    issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0, -1, "mult");
    issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 1'b0, 4, "mflo_stalls");
    issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0, -1, "mult");
    funcode = 6'h12;
    rd_id = 5'd7;
    #1;
    check("md_pre_stall", stall_id, 1);
    check("md_pre_exAluOp", ex_ALUOp, 7);
    rst = 1'b1;
    #1;
    check("md_rst_stall", stall_id, 0);
    check("md_rst_exAluOp", ex_ALUOp, 0);
    check("md_rst_exSigned", ex_isSigned, 0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 1'b0, 0, "md_post_rst_stalls");
`endif
    for (int k = 0; k < 400; k++) begin
      logic [5:0] op, fn;
      op = opTbl[$urandom_range(0, 29)];
      fn = (op == 6'h00) ? fnTbl[$urandom_range(0, 12)] : 6'($urandom);
      issue(op, fn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), -1, "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
